axi_mem_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite-style arbiter that shares the simulated SRAM port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the core's memory-facing masters and the single SRAM slave. It serialises traffic so exactly one transaction is outstanding at the slave at any time. Grant uses fixed priority with a starvation guard for the IFU.

---
 rtl/mem_bus_pkg.sv | 34 +++
 rtl/axi_mem_arbiter_if.sv | 36 +++
 rtl/arb_starve_ctr.sv | 27 ++
 rtl/axi_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-side bus arbiter: FSM states, grant
// owner encodings and AXI response codes.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFU_AR = 3'd1,
    IFU_R  = 3'd2,
    LSU_AR = 3'd3,
    LSU_R  = 3'd4,
    LSU_W  = 3'd5,
    LSU_B  = 3'd6
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IFU  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Grant owner implied by an arbiter state.
  function automatic logic [1:0] owner_of(arb_state_t st);
    logic [1:0] o;
    o = OWN_NONE;
    case (st)
      IFU_AR, IFU_R:               o = OWN_IFU;
      LSU_AR, LSU_R, LSU_W, LSU_B: o = OWN_LSU;
      default:                     o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// AXI4-Lite-style bus bundle (AR, R, AW, W, B channels).
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1; the source holds valid and payload stable until that edge, and
// ready may depend combinationally on valid.
interface axi_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of LSU grants taken while the IFU was kept waiting.
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             inc,
  input  logic             clr,
  output logic             at_limit,
  output logic [CNT_W-1:0] cnt
);

  assign at_limit = (cnt == CNT_W'(LIMIT));

  // Clear wins over increment; increment stops at the limit.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave arbiter. One
// transaction is outstanding at the slave at a time; the LSU has fixed
// priority except that the IFU is forced through after STARVE_LIMIT
// consecutive LSU grants taken while it waited.
module axi_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  axi_mem_arbiter_if.slave  ifu,
  axi_mem_arbiter_if.slave  lsu,
  axi_mem_arbiter_if.master s,
  output logic [1:0]        owner,
  output arb_state_t        state_dbg,
  output logic [CNT_W-1:0]  starve_cnt
);

  arb_state_t state_q, state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       starve_inc, starve_clr, starve_at_limit;
  logic       aw_fire, w_fire;
  logic       unused_ifu_wr;

  // The IFU never writes; its write-side inputs are deliberately ignored.
  assign unused_ifu_wr = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                           ifu.wvalid, ifu.bready};

  assign owner     = owner_of(state_q);
  assign state_dbg = state_q;
  assign aw_fire   = s.awvalid && s.awready;
  assign w_fire    = s.wvalid && s.wready;

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .aclk     (aclk),
    .areset   (areset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_at_limit),
    .cnt      (starve_cnt)
  );

  // State and write-channel completion flags.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Grant decision in IDLE and handshake-driven sequencing elsewhere.
  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ifu.arvalid) starve_clr = 1'b1;
        if (ifu.arvalid && starve_at_limit) begin
          state_d    = IFU_AR;
          starve_clr = 1'b1;
        end else if (lsu.awvalid || lsu.wvalid) begin
          state_d    = LSU_W;
          starve_inc = ifu.arvalid;
        end else if (lsu.arvalid) begin
          state_d    = LSU_AR;
          starve_inc = ifu.arvalid;
        end else if (ifu.arvalid) begin
          state_d    = IFU_AR;
          starve_clr = 1'b1;
        end
      end
      IFU_AR: if (s.arvalid && s.arready) state_d = IFU_R;
      IFU_R:  if (s.rvalid && s.rready)   state_d = IDLE;
      LSU_AR: if (s.arvalid && s.arready) state_d = LSU_R;
      LSU_R:  if (s.rvalid && s.rready)   state_d = IDLE;
      LSU_W: begin
        // AW and W may complete in either order; B waits for both.
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = LSU_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      LSU_B:   if (s.bvalid && s.bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel muxing: only the owner's channels for the current phase are
  // connected; everything else is held at zero.
  always_comb begin
    s.araddr    = '0;
    s.arvalid   = 1'b0;
    s.rready    = 1'b0;
    s.awaddr    = '0;
    s.awvalid   = 1'b0;
    s.wdata     = '0;
    s.wstrb     = '0;
    s.wvalid    = 1'b0;
    s.bready    = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = RESP_OKAY;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = RESP_OKAY;
    ifu.bvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = RESP_OKAY;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = RESP_OKAY;
    lsu.bvalid  = 1'b0;
    case (state_q)
      IFU_AR: begin
        s.araddr    = ifu.araddr;
        s.arvalid   = ifu.arvalid;
        ifu.arready = s.arready;
      end
      IFU_R: begin
        ifu.rdata  = s.rdata;
        ifu.rresp  = s.rresp;
        ifu.rvalid = s.rvalid;
        s.rready   = ifu.rready;
      end
      LSU_AR: begin
        s.araddr    = lsu.araddr;
        s.arvalid   = lsu.arvalid;
        lsu.arready = s.arready;
      end
      LSU_R: begin
        lsu.rdata  = s.rdata;
        lsu.rresp  = s.rresp;
        lsu.rvalid = s.rvalid;
        s.rready   = lsu.rready;
      end
      LSU_W: begin
        s.awaddr    = lsu.awaddr;
        s.awvalid   = lsu.awvalid && !aw_done_q;
        lsu.awready = s.awready && !aw_done_q;
        s.wdata     = lsu.wdata;
        s.wstrb     = lsu.wstrb;
        s.wvalid    = lsu.wvalid && !w_done_q;
        lsu.wready  = s.wready && !w_done_q;
      end
      LSU_B: begin
        lsu.bresp  = s.bresp;
        lsu.bvalid = s.bvalid;
        s.bready   = lsu.bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter with an always-ready SRAM model that
// answers one cycle after each address/data handshake.
module tb_axi_mem_arbiter;
  import mem_bus_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(4 + 1);

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifu_bus ();
  axi_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lsu_bus ();
  axi_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  logic [1:0]       owner;
  arb_state_t       state_dbg;
  logic [CNT_W-1:0] starve_cnt;

  axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .ifu        (ifu_bus.slave),
    .lsu        (lsu_bus.slave),
    .s          (s_bus.master),
    .owner      (owner),
    .state_dbg  (state_dbg),
    .starve_cnt (starve_cnt)
  );

  // ---------------- SRAM slave model ----------------
  logic [DATA_W-1:0] sl_rdata = '0;
  logic [1:0]        sl_rresp = RESP_OKAY;
  logic              aw_got = 1'b0;
  logic              w_got = 1'b0;
  int                ar_hs = 0;
  int                aw_hs = 0;
  int                w_hs = 0;
  int                b_hs = 0;

  assign s_bus.arready = 1'b1;
  assign s_bus.awready = 1'b1;
  assign s_bus.wready  = 1'b1;

  always @(posedge aclk) begin
    if (areset) begin
      s_bus.rvalid <= 1'b0;
      s_bus.rdata  <= '0;
      s_bus.rresp  <= RESP_OKAY;
      s_bus.bvalid <= 1'b0;
      s_bus.bresp  <= RESP_OKAY;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
    end else begin
      if (s_bus.arvalid && s_bus.arready) begin
        ar_hs        <= ar_hs + 1;
        s_bus.rvalid <= 1'b1;
        s_bus.rdata  <= sl_rdata;
        s_bus.rresp  <= sl_rresp;
      end else if (s_bus.rvalid && s_bus.rready) begin
        s_bus.rvalid <= 1'b0;
        s_bus.rdata  <= '0;
        s_bus.rresp  <= RESP_OKAY;
      end
      if (s_bus.awvalid && s_bus.awready) aw_hs <= aw_hs + 1;
      if (s_bus.wvalid && s_bus.wready) w_hs <= w_hs + 1;
      if ((aw_got || (s_bus.awvalid && s_bus.awready)) &&
          (w_got || (s_bus.wvalid && s_bus.wready))) begin
        s_bus.bvalid <= 1'b1;
        s_bus.bresp  <= RESP_OKAY;
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
      end else begin
        if (s_bus.awvalid && s_bus.awready) aw_got <= 1'b1;
        if (s_bus.wvalid && s_bus.wready) w_got <= 1'b1;
      end
      if (s_bus.bvalid && s_bus.bready) begin
        b_hs         <= b_hs + 1;
        s_bus.bvalid <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge aclk);
  endtask

  task automatic idle_masters();
    ifu_bus.araddr = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b0;
    ifu_bus.awaddr = '0; ifu_bus.awvalid = 1'b0; ifu_bus.wdata = '0;
    ifu_bus.wstrb = '0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
    lsu_bus.araddr = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b0;
    lsu_bus.awaddr = '0; lsu_bus.awvalid = 1'b0; lsu_bus.wdata = '0;
    lsu_bus.wstrb = '0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b0;
  endtask

  // Time bound for the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int base_ar, base_aw, base_w, base_b, grants;

  initial begin
    idle_masters();
    areset = 1'b1;
    step();
    step();
    // Reset state
    chk("rst_state", state_dbg, IDLE);
    chk("rst_owner", owner, OWN_NONE);
    chk("rst_starve", starve_cnt, 0);
    chk("rst_s_valids", {s_bus.arvalid, s_bus.awvalid, s_bus.wvalid, s_bus.rready, s_bus.bready}, 0);
    chk("rst_m_outs", {ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.awready,
                       lsu_bus.wready, lsu_bus.rvalid, lsu_bus.bvalid}, 0);
    areset = 1'b0;
    step();

    // T1: lone IFU read
    base_ar = ar_hs;
    sl_rdata = 64'hDEAD_BEEF_0000_0001;
    sl_rresp = RESP_OKAY;
    ifu_bus.araddr = 32'h8000_0000; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    chk("t1_owner_c1", owner, OWN_NONE);
    step();
    chk("t1_owner_c2", owner, OWN_IFU);
    chk("t1_s_araddr", s_bus.araddr, 64'h8000_0000);
    chk("t1_s_arvalid", s_bus.arvalid, 1);
    chk("t1_lsu_readys_c2", {lsu_bus.arready, lsu_bus.awready, lsu_bus.wready}, 0);
    step();
    chk("t1_owner_c3", owner, OWN_IFU);
    chk("t1_rvalid", ifu_bus.rvalid, 1);
    chk("t1_rdata", ifu_bus.rdata, 64'hDEAD_BEEF_0000_0001);
    chk("t1_lsu_readys_c3", {lsu_bus.arready, lsu_bus.awready, lsu_bus.wready}, 0);
    ifu_bus.arvalid = 1'b0;
    step();
    chk("t1_owner_c4", owner, OWN_NONE);
    chk("t1_rvalid_off", ifu_bus.rvalid, 0);
    chk("t1_ar_count", ar_hs - base_ar, 1);

    // T2a: LSU write, AW and W together
    base_aw = aw_hs; base_w = w_hs; base_b = b_hs;
    lsu_bus.awaddr = 32'h8000_0010; lsu_bus.awvalid = 1'b1;
    lsu_bus.wdata = 64'h1122_3344_5566_7788; lsu_bus.wstrb = 8'h0F; lsu_bus.wvalid = 1'b1;
    lsu_bus.bready = 1'b1;
    step();
    chk("t2_state_w", state_dbg, LSU_W);
    chk("t2_owner", owner, OWN_LSU);
    chk("t2_s_awaddr", s_bus.awaddr, 64'h8000_0010);
    chk("t2_s_wdata", s_bus.wdata, 64'h1122_3344_5566_7788);
    chk("t2_s_wstrb", s_bus.wstrb, 8'h0F);
    chk("t2_s_valids", {s_bus.awvalid, s_bus.wvalid}, 2'b11);
    step();
    chk("t2_bvalid", lsu_bus.bvalid, 1);
    chk("t2_bresp", lsu_bus.bresp, RESP_OKAY);
    lsu_bus.awvalid = 1'b0; lsu_bus.wvalid = 1'b0;
    step();
    chk("t2_state_idle", state_dbg, IDLE);
    chk("t2_hs_counts", {8'(aw_hs - base_aw), 8'(w_hs - base_w), 8'(b_hs - base_b)}, 24'h010101);

    // T2b: W arrives two cycles after AW
    base_aw = aw_hs; base_w = w_hs; base_b = b_hs;
    lsu_bus.awaddr = 32'h8000_0018; lsu_bus.awvalid = 1'b1;
    lsu_bus.wdata = 64'hA5A5_A5A5_5A5A_5A5A; lsu_bus.wstrb = 8'hF0;
    step();
    chk("t2b_only_aw", {s_bus.awvalid, s_bus.wvalid}, 2'b10);
    step();
    chk("t2b_hold_w", state_dbg, LSU_W);
    chk("t2b_aw_masked", {s_bus.awvalid, lsu_bus.awready}, 0);
    lsu_bus.awvalid = 1'b0;
    lsu_bus.wvalid = 1'b1;
    step();
    chk("t2b_state_b", state_dbg, LSU_B);
    chk("t2b_bvalid", lsu_bus.bvalid, 1);
    lsu_bus.wvalid = 1'b0;
    step();
    chk("t2b_hs_counts", {8'(aw_hs - base_aw), 8'(w_hs - base_w), 8'(b_hs - base_b)}, 24'h010101);

    // T3: LSU read and write raised together; write goes first
    base_ar = ar_hs;
    sl_rdata = 64'h0000_1111_2222_3333;
    lsu_bus.araddr = 32'h8000_0020; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
    lsu_bus.awaddr = 32'h8000_0028; lsu_bus.awvalid = 1'b1;
    lsu_bus.wdata = 64'h9; lsu_bus.wstrb = 8'hFF; lsu_bus.wvalid = 1'b1;
    step();
    chk("t3_write_first", state_dbg, LSU_W);
    chk("t3_no_arready", lsu_bus.arready, 0);
    step();
    chk("t3_b_phase", lsu_bus.bvalid, 1);
    lsu_bus.awvalid = 1'b0; lsu_bus.wvalid = 1'b0;
    step();
    chk("t3_idle_between", state_dbg, IDLE);
    step();
    chk("t3_read_granted", state_dbg, LSU_AR);
    chk("t3_s_araddr", s_bus.araddr, 64'h8000_0020);
    step();
    chk("t3_rdata", lsu_bus.rdata, 64'h0000_1111_2222_3333);
    lsu_bus.arvalid = 1'b0;
    step();
    chk("t3_ar_count", ar_hs - base_ar, 1);

    // T4: continuous IFU and LSU reads; starvation guard
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(OWN_LSU);
      exp_q.push_back(OWN_IFU);
    end
    sl_rdata = 64'h4444;
    ifu_bus.araddr = 32'h8000_0100; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    lsu_bus.araddr = 32'h8000_0200; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b1;
    grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 10; cyc++) begin
      step();
      if (state_dbg == IFU_AR || state_dbg == LSU_AR) begin
        chk($sformatf("t4_grant%0d", grants), owner, exp_q.pop_front());
        grants++;
      end
    end
    chk("t4_grant_count", grants, 10);
    step();
    ifu_bus.arvalid = 1'b0; lsu_bus.arvalid = 1'b0;
    step();
    chk("t4_idle_end", state_dbg, IDLE);

    // T5: slave holds rvalid while LSU is not ready
    sl_rdata = 64'h0123_4567_89AB_CDEF;
    sl_rresp = RESP_SLVERR;
    lsu_bus.araddr = 32'h8000_0030; lsu_bus.arvalid = 1'b1; lsu_bus.rready = 1'b0;
    step();
    step();
    lsu_bus.arvalid = 1'b0;
    sl_rdata = 64'hCAFE_F00D_0000_0005;
    sl_rresp = RESP_OKAY;
    ifu_bus.araddr = 32'h8000_0040; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_hold%0d_state", i), state_dbg, LSU_R);
      chk($sformatf("t5_hold%0d_ifu", i), {ifu_bus.arready, owner}, {1'b0, OWN_LSU});
      chk($sformatf("t5_hold%0d_rvalid", i), lsu_bus.rvalid, 1);
      if (i < 2) step();
    end
    chk("t5_rresp", lsu_bus.rresp, RESP_SLVERR);
    chk("t5_rdata", lsu_bus.rdata, 64'h0123_4567_89AB_CDEF);
    lsu_bus.rready = 1'b1;
    step();
    chk("t5_back_idle", {state_dbg, owner}, {IDLE, OWN_NONE});
    step();
    chk("t5_ifu_grant", state_dbg, IFU_AR);
    step();
    chk("t5_ifu_rdata", ifu_bus.rdata, 64'hCAFE_F00D_0000_0005);
    ifu_bus.arvalid = 1'b0;
    step();

    // T6: reset while IFU_R waits for rready
    sl_rdata = 64'h5555_6666_7777_8888;
    ifu_bus.araddr = 32'h8000_0050; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b0;
    step();
    step();
    chk("t6_in_r", state_dbg, IFU_R);
    chk("t6_rvalid_before", ifu_bus.rvalid, 1);
    ifu_bus.arvalid = 1'b0;
    areset = 1'b1;
    step();
    chk("t6_state", state_dbg, IDLE);
    chk("t6_owner", owner, OWN_NONE);
    chk("t6_starve", starve_cnt, 0);
    chk("t6_outs", {ifu_bus.rvalid, s_bus.rready, s_bus.arvalid, lsu_bus.bvalid}, 0);
    chk("t6_rdata", ifu_bus.rdata, 0);
    areset = 1'b0;
    sl_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    ifu_bus.araddr = 32'h8000_0060; ifu_bus.arvalid = 1'b1; ifu_bus.rready = 1'b1;
    step();
    chk("t6_re_ar", s_bus.araddr, 64'h8000_0060);
    step();
    chk("t6_re_rdata", ifu_bus.rdata, 64'h0F0F_0F0F_0F0F_0F0F);
    ifu_bus.arvalid = 1'b0;
    step();
    chk("t6_re_idle", state_dbg, IDLE);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
